// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - valid/ready stream bundle with burst framing
interface fifo_stream_reader_if #(
    parameter int WIDTH = 16
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-port drainer to framed stream; optional checker FIFO_READER_UNDERFLOW_CHK_EN
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    fifo_stream_reader_if.master  m,
    output logic                  busy,
    output logic                  err
);
    localparam int                BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    logic                  inflight;
    logic [1:0]            occ;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [BEAT_W-1:0]     beat;
    logic [FIFO_WIDTH-1:0] buf_mem [3];
    logic [2:0]            committed;
    logic                  capture;
    logic                  pop;

    // Three-slot ring pointer: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Slots already promised: buffered words plus the word on its way from the FIFO.
    assign committed  = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en = en & ~fifo_empty & (committed < 3'd3) & ~rst;
    assign capture    = inflight;

    assign m.valid = (occ != 2'd0);
    assign m.data  = buf_mem[rd_ptr];
    assign m.last  = m.valid & (beat == BEAT_MAX);
    assign pop     = m.valid & m.ready;
    assign busy    = m.valid | inflight;

    // A read strobed last cycle has its data on fifo_data_out this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Ring pointers and occupancy; capture and pop together leave occ unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ    <= 2'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            if (capture) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({capture, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Buffer storage; cleared on reset so m_data reads zero while idle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (capture) begin
            buf_mem[wr_ptr] <= fifo_data_out;
        end
    end

    // Beat counter advances on each accepted word and wraps at the burst length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (pop) begin
            beat <= (beat == BEAT_MAX) ? '0 : beat + BEAT_W'(1);
        end
    end

`ifdef FIFO_READER_UNDERFLOW_CHK_EN
    // Sticky error on FIFO underflow or a read strobe against an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fifo_underflow | (fifo_rd_en & fifo_empty)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_underflow;
    assign unused_underflow = fifo_underflow;
    assign err              = 1'b0;
`endif

endmodule
